inv_cipher: RTL

- Iterative AES inverse cipher (decryption datapath), one round per clock, for AES-128/192/256.
- Counterpart of `cipher`: consumes a ciphertext block plus round keys delivered in reverse order, and produces the plaintext.
- Round keys come from `key_expansion` running with Rev=1, which supplies key Nr first and key 0 last.
- Byte/bit ordering matches the rest of the AES datapath: [0:127], byte 0 = bits [0:7], column-major state.

---
 rtl/inv_cipher_pkg.sv | 68 ++++++
 rtl/inv_cipher_inv_sbox.sv | 30 +++
 rtl/inv_cipher.sv | 113 +++++++++++
 3 files changed

// File: rtl/inv_cipher_pkg.sv
// Shared AES definitions for the inverse cipher: round counts, mode codes,
// FSM state encoding and the GF(2^8) constant multipliers used by
// InvMixColumns (polynomial 0x11b).
package inv_cipher_pkg;

    localparam logic [4:0] NR_128 = 5'd10;
    localparam logic [4:0] NR_192 = 5'd12;
    localparam logic [4:0] NR_256 = 5'd14;

    localparam logic [1:0] MODE_128  = 2'd0;
    localparam logic [1:0] MODE_192  = 2'd1;
    localparam logic [1:0] MODE_256  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // INIT is folded into the start edge taken from IDLE; it is kept in the
    // encoding so the state names match the rest of the AES datapath.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [4:0] nr_of_mode(input logic [1:0] m);
        case (m)
            MODE_128: return NR_128;
            MODE_192: return NR_192;
            default:  return NR_256;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_cipher_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module inv_cipher_inv_sbox
    import inv_cipher_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher, one round per clock, AES-128/192/256.
// Round keys arrive newest-first (key Nr on the start edge, key 0 last);
// Round reports which key index is being consumed this cycle.
module inv_cipher
    import inv_cipher_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         E,
    input  logic [0:1]   mode,
    input  logic [0:127] Data,
    input  logic [0:127] roundKey,
    output logic [0:127] OUT,
    output logic         EndFlag,
    output logic [4:0]   Round
);

    state_e       fsm_q;
    logic [0:127] state_q;
    logic [0:127] out_q;
    logic         end_q;
    logic [4:0]   round_q;

    logic [0:127] sr;      // InvShiftRows(state)
    logic [0:127] sb;      // InvSubBytes(sr)
    logic [0:127] ark;     // AddRoundKey(sb, roundKey)
    logic [0:127] imc;     // InvMixColumns(ark)
    logic [0:127] state_d; // next state for a ROUND edge

    // InvShiftRows: row rw rotates right by rw columns.
    always_comb begin
        sr = '0;
        for (int c = 0; c < NB; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                sr[8*(rw + 4*c) +: 8] = state_q[8*(rw + 4*((c - rw + NB) % NB)) +: 8];
            end
        end
    end

    for (genvar i = 0; i < 4*NB; i++) begin : g_isb
        inv_cipher_inv_sbox u_isb (
            .byte_i (sr[8*i +: 8]),
            .byte_o (sb[8*i +: 8])
        );
    end

    assign ark = sb ^ roundKey;

    // InvMixColumns: b_r = 0e*a_r ^ 0b*a_r+1 ^ 0d*a_r+2 ^ 09*a_r+3 per column.
    always_comb begin
        imc = '0;
        for (int c = 0; c < NB; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                imc[8*(rw + 4*c) +: 8] = mul_0e(ark[8*(((rw    ) % 4) + 4*c) +: 8])
                                       ^ mul_0b(ark[8*(((rw + 1) % 4) + 4*c) +: 8])
                                       ^ mul_0d(ark[8*(((rw + 2) % 4) + 4*c) +: 8])
                                       ^ mul_09(ark[8*(((rw + 3) % 4) + 4*c) +: 8]);
            end
        end
    end

    // The last round (key 0) skips InvMixColumns.
    assign state_d = (round_q == 5'd0) ? ark : imc;

    // Control FSM with registered datapath state, result and status.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            out_q   <= '0;
            end_q   <= 1'b0;
            round_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (E && (mode != MODE_RSVD)) begin
                        state_q <= Data ^ roundKey;
                        round_q <= nr_of_mode(mode) - 5'd1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    if (!E) begin
                        fsm_q <= IDLE;
                    end else begin
                        state_q <= state_d;
                        if (round_q == 5'd0) begin
                            out_q <= state_d;
                            end_q <= 1'b1;
                            fsm_q <= DONE;
                        end else begin
                            round_q <= round_q - 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (!E) begin
                        end_q <= 1'b0;
                        fsm_q <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign OUT     = out_q;
    assign EndFlag = end_q;
    assign Round   = round_q;

endmodule
